// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage PC generator.
package pc_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } pc_state_e;

  localparam int unsigned PC_W_DEF   = 13;
  localparam int unsigned PC_INC_DEF = 4;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry buffer for a redirect target that arrived while fetch was stalled.
module pc_redirect_buf
  import pc_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture,
  input  logic [PC_W-1:0] capture_pc,
  input  logic            clear,
  output logic            pend_valid,
  output logic [PC_W-1:0] pend_pc
);

  // Capture overwrites any older target; clear drops the entry once it is consumed or superseded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_pc    <= '0;
    end else if (capture) begin
      pend_valid <= 1'b1;
      pend_pc    <= capture_pc;
    end else if (clear) begin
      pend_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential increment, bubble hold, level stall, buffered redirect.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned PC_W        = PC_W_DEF,
  parameter int unsigned RESET_VEC   = 0,
  parameter int unsigned INC         = PC_INC_DEF,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            bubble_req_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_plus_o,
  output logic            hold_o,
  output logic            pend_o,
  output logic            redirect_taken_o
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

  // Parameter sanity checks at elaboration.
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("pc_gen: HOLD_CYCLES must be at least 1");
  end
  if (64'(RESET_VEC) >= (64'd1 << PC_W)) begin : g_bad_reset_vec
    $error("pc_gen: RESET_VEC does not fit in PC_W bits");
  end

  pc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             taken_q, taken_d;

  logic             buf_capture;
  logic             buf_clear;
  logic             pend_valid;
  logic [PC_W-1:0]  pend_pc;

  pc_redirect_buf #(
    .PC_W (PC_W)
  ) u_redirect_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture    (buf_capture),
    .capture_pc (redirect_pc_i),
    .clear      (buf_clear),
    .pend_valid (pend_valid),
    .pend_pc    (pend_pc)
  );

  // State, counter, PC and redirect-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pc_q    <= PC_W'(RESET_VEC);
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
    end
  end

  // Next-state: stall > live redirect > pending redirect > hold countdown > sequential advance.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    taken_d     = 1'b0;
    buf_capture = 1'b0;
    buf_clear   = 1'b0;

    if (stall_i) begin
      buf_capture = redirect_i;
    end else if (redirect_i) begin
      pc_d      = redirect_pc_i;
      buf_clear = 1'b1;
      state_d   = RUN;
      cnt_d     = '0;
      taken_d   = 1'b1;
    end else if (pend_valid) begin
      pc_d      = pend_pc;
      buf_clear = 1'b1;
      state_d   = RUN;
      cnt_d     = '0;
      taken_d   = 1'b1;
    end else if (state_q == HOLD) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = RUN;
      end
    end else begin
      pc_d = pc_q + PC_W'(INC);
      if (bubble_req_i) begin
        state_d = HOLD;
        cnt_d   = CNT_W'(HOLD_CYCLES);
      end
    end
  end

  assign pc_o             = pc_q;
  assign pc_plus_o        = pc_q + PC_W'(INC);
  assign hold_o           = (state_q == HOLD);
  assign pend_o           = pend_valid;
  assign redirect_taken_o = taken_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed steps queue expectations, a monitor pops and compares.
module tb_pc_gen;

  localparam int unsigned PW = 13;

  logic          clk = 1'b0;
  logic          rst_n;

  logic          stall0, bub0, red0;
  logic [PW-1:0] rpc0;
  logic [PW-1:0] pc0, plus0;
  logic          hold0, pend0, taken0;

  logic          stall1, bub1, red1;
  logic [PW-1:0] rpc1;
  logic [PW-1:0] pc1, plus1;
  logic          hold1, pend1, taken1;

  pc_gen #(
    .PC_W        (PW),
    .RESET_VEC   (0),
    .INC         (4),
    .HOLD_CYCLES (2)
  ) dut0 (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall0),
    .bubble_req_i     (bub0),
    .redirect_i       (red0),
    .redirect_pc_i    (rpc0),
    .pc_o             (pc0),
    .pc_plus_o        (plus0),
    .hold_o           (hold0),
    .pend_o           (pend0),
    .redirect_taken_o (taken0)
  );

  pc_gen #(
    .PC_W        (PW),
    .RESET_VEC   (0),
    .INC         (4),
    .HOLD_CYCLES (1)
  ) dut1 (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall1),
    .bubble_req_i     (bub1),
    .redirect_i       (red1),
    .redirect_pc_i    (rpc1),
    .pc_o             (pc1),
    .pc_plus_o        (plus1),
    .hold_o           (hold1),
    .pend_o           (pend1),
    .redirect_taken_o (taken1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            which;
    logic [PW-1:0] pc;
    logic          hold;
    logic          pend;
    logic          taken;
    string         tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;
  event sample_now;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares the DUT against the oldest queued expectation after each edge or snapshot.
  initial begin : monitor
    exp_t          e;
    logic [PW-1:0] apc, aplus, eplus;
    logic          ah, ap, at;
    int            idle;
    idle = 0;
    forever begin
      @(posedge clk or sample_now);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.which == 1'b0) begin
          apc = pc0; aplus = plus0; ah = hold0; ap = pend0; at = taken0;
        end else begin
          apc = pc1; aplus = plus1; ah = hold1; ap = pend1; at = taken1;
        end
        eplus = e.pc + PW'(4);
        chk({e.tag, " pc"},    apc,       e.pc);
        chk({e.tag, " plus"},  aplus,     eplus);
        chk({e.tag, " hold"},  PW'(ah),   PW'(e.hold));
        chk({e.tag, " pend"},  PW'(ap),   PW'(e.pend));
        chk({e.tag, " taken"}, PW'(at),   PW'(e.taken));
      end
      if (stim_done) begin
        if (q.size() == 0) begin
          $display("Result: errors=%0d of %0d checks", errors, checks);
          $finish;
        end
        idle++;
        if (idle > 20) begin
          checks++;
          errors++;
          $display("FAIL drain: %0d expectations left, expected 0", q.size());
          $display("Result: errors=%0d of %0d checks", errors, checks);
          $finish;
        end
      end
    end
  end

  function automatic exp_t mk(input bit which, input logic [PW-1:0] pc, input logic h,
                              input logic p, input logic t, input string tag);
    exp_t e;
    e.which = which; e.pc = pc; e.hold = h; e.pend = p; e.taken = t; e.tag = tag;
    return e;
  endfunction

  // Drive one cycle of inputs at a negedge and queue the state expected after the next posedge.
  task automatic step(input bit which, input logic st, input logic bu, input logic re,
                      input logic [PW-1:0] rpc, input logic [PW-1:0] epc,
                      input logic eh, input logic ep, input logic et, input string tag);
    if (which == 1'b0) begin
      stall0 = st; bub0 = bu; red0 = re; rpc0 = rpc;
      stall1 = 1'b0; bub1 = 1'b0; red1 = 1'b0; rpc1 = '0;
    end else begin
      stall1 = st; bub1 = bu; red1 = re; rpc1 = rpc;
      stall0 = 1'b0; bub0 = 1'b0; red0 = 1'b0; rpc0 = '0;
    end
    q.push_back(mk(which, epc, eh, ep, et, tag));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Queue an expectation and have the monitor sample it immediately, without a clock edge.
  task automatic snap(input bit which, input logic [PW-1:0] epc, input string tag);
    q.push_back(mk(which, epc, 1'b0, 1'b0, 1'b0, tag));
    ->sample_now;
    #2;
  endtask

  initial begin : stimulus
    rst_n = 1'b0;
    stall0 = 1'b0; bub0 = 1'b0; red0 = 1'b0; rpc0 = '0;
    stall1 = 1'b0; bub1 = 1'b0; red1 = 1'b0; rpc1 = '0;
    #1;
    snap(1'b0, 13'h000, "reset0");
    snap(1'b1, 13'h000, "reset1");

    @(negedge clk);
    rst_n = 1'b1;

    // Free run.
    step(0, 0, 0, 0, 13'h0, 13'h004, 0, 0, 0, "run1");
    step(0, 0, 0, 0, 13'h0, 13'h008, 0, 0, 0, "run2");
    step(0, 0, 0, 0, 13'h0, 13'h00C, 0, 0, 0, "run3");
    step(0, 0, 0, 0, 13'h0, 13'h010, 0, 0, 0, "run4");

    // Asynchronous reset between clock edges.
    #2;
    rst_n = 1'b0;
    snap(1'b0, 13'h000, "async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Bubble at PC 0x008: advance, then hold for two cycles.
    step(0, 0, 0, 0, 13'h0, 13'h004, 0, 0, 0, "pre_bub1");
    step(0, 0, 0, 0, 13'h0, 13'h008, 0, 0, 0, "pre_bub2");
    step(0, 0, 1, 0, 13'h0, 13'h00C, 1, 0, 0, "bub_adv");
    step(0, 0, 0, 0, 13'h0, 13'h00C, 1, 0, 0, "bub_h1");
    step(0, 0, 0, 0, 13'h0, 13'h00C, 0, 0, 0, "bub_h2");
    step(0, 0, 0, 0, 13'h0, 13'h010, 0, 0, 0, "bub_resume");

    // Redirects during a stall are buffered; the newest wins on release.
    step(0, 1, 0, 1, 13'h100, 13'h010, 0, 1, 0, "stall_red1");
    step(0, 1, 1, 0, 13'h000, 13'h010, 0, 1, 0, "stall_mid");
    step(0, 1, 0, 1, 13'h200, 13'h010, 0, 1, 0, "stall_red2");
    step(0, 0, 0, 0, 13'h000, 13'h200, 0, 0, 1, "pend_load");
    step(0, 0, 0, 0, 13'h000, 13'h204, 0, 0, 0, "pend_after");

    // Redirect plus bubble during HOLD: redirect wins, bubble ignored.
    step(0, 0, 1, 0, 13'h000, 13'h208, 1, 0, 0, "hold_enter");
    step(0, 0, 1, 1, 13'h040, 13'h040, 0, 0, 1, "hold_redir");
    step(0, 0, 0, 0, 13'h000, 13'h044, 0, 0, 0, "hold_redir2");
    step(0, 0, 0, 0, 13'h000, 13'h048, 0, 0, 0, "hold_redir3");

    // Wrap at the top of the PC space.
    step(0, 0, 0, 1, 13'h1FF8, 13'h1FF8, 0, 0, 1, "wrap_set");
    step(0, 0, 0, 0, 13'h0000, 13'h1FFC, 0, 0, 0, "wrap_top");
    step(0, 0, 0, 0, 13'h0000, 13'h0000, 0, 0, 0, "wrap_zero");
    step(0, 0, 0, 0, 13'h0000, 13'h0004, 0, 0, 0, "wrap_four");

    // HOLD_CYCLES=1: stall in the hold cycle stretches the hold.
    step(1, 0, 0, 1, 13'h100, 13'h100, 0, 0, 1, "h1_set");
    step(1, 0, 1, 0, 13'h000, 13'h104, 1, 0, 0, "h1_bub");
    step(1, 1, 0, 0, 13'h000, 13'h104, 1, 0, 0, "h1_stall1");
    step(1, 1, 0, 0, 13'h000, 13'h104, 1, 0, 0, "h1_stall2");
    step(1, 0, 0, 0, 13'h000, 13'h104, 0, 0, 0, "h1_hold");
    step(1, 0, 0, 0, 13'h000, 13'h108, 0, 0, 0, "h1_resume");

    stim_done = 1'b1;
  end

endmodule
